// File: rtl/reverse_hash_peeler.sv
// Inverts the forward hash step h' = (h*33) ^ c by peeling a known suffix off a
// target hash, one char per cycle, last char first; flags a match against a seed.
module reverse_hash_peeler #(
    parameter int          MAX_CHARS = 8,
    parameter int          CHAR_W    = 7,
    parameter logic [31:0] INV33     = 32'h3E0F83E1,
    localparam int         LEN_W     = $clog2(MAX_CHARS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_hash,
    input  logic [MAX_CHARS*CHAR_W-1:0] in_chars,
    input  logic [LEN_W-1:0]            in_len,
    input  logic [31:0]                 in_seed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_hash,
    output logic                        out_is_seed
);

    typedef enum logic [1:0] {IDLE, PEEL, DONE} state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 h_q, h_d;
    logic [31:0]                 seed_q, seed_d;
    logic [LEN_W-1:0]            cnt_q, cnt_d;
    logic [MAX_CHARS*CHAR_W-1:0] chars_q, chars_d;
    logic [31:0]                 out_hash_q, out_hash_d;
    logic                        out_is_seed_q, out_is_seed_d;

    logic [CHAR_W-1:0]           char_arr [MAX_CHARS];
    logic [CHAR_W-1:0]           cur_char;
    logic [31:0]                 h_peel;
    logic [LEN_W-1:0]            len_clamped;

    generate
        for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_unpack
            assign char_arr[gi] = chars_q[gi*CHAR_W +: CHAR_W];
        end
    endgenerate

    // cnt counts remaining chars, so the char to remove next is chars[cnt-1]
    always_comb begin
        cur_char = '0;
        for (int k = 0; k < MAX_CHARS; k++) begin
            if (cnt_q == LEN_W'(k + 1)) cur_char = char_arr[k];
        end
    end

    assign h_peel      = (h_q ^ {{(32-CHAR_W){1'b0}}, cur_char}) * INV33;
    assign len_clamped = (in_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : in_len;

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        seed_d        = seed_q;
        cnt_d         = cnt_q;
        chars_d       = chars_q;
        out_hash_d    = out_hash_q;
        out_is_seed_d = out_is_seed_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    h_d     = in_hash;
                    seed_d  = in_seed;
                    chars_d = in_chars;
                    cnt_d   = len_clamped;
                    if (len_clamped == '0) begin
                        state_d       = DONE;
                        out_hash_d    = in_hash;
                        out_is_seed_d = (in_hash == in_seed);
                    end else begin
                        state_d = PEEL;
                    end
                end
            end
            PEEL: begin
                h_d   = h_peel;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d       = DONE;
                    out_hash_d    = h_peel;
                    out_is_seed_d = (h_peel == seed_q);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_q           <= '0;
            seed_q        <= '0;
            cnt_q         <= '0;
            chars_q       <= '0;
            out_hash_q    <= '0;
            out_is_seed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            seed_q        <= seed_d;
            cnt_q         <= cnt_d;
            chars_q       <= chars_d;
            out_hash_q    <= out_hash_d;
            out_is_seed_q <= out_is_seed_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_hash    = out_hash_q;
    assign out_is_seed = out_is_seed_q;

endmodule

// File: tb/tb_reverse_hash_peeler.sv
// Directed and randomized checks of reverse_hash_peeler against a forward-hash
// reference model: results must equal forward prefix states.
module tb_reverse_hash_peeler;

    localparam int MAX_CHARS = 8;
    localparam int CHAR_W    = 7;
    localparam int LEN_W     = 4;
    localparam int CW        = MAX_CHARS * CHAR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_hash = '0;
    logic [CW-1:0]     in_chars = '0;
    logic [LEN_W-1:0]  in_len = '0;
    logic [31:0]       in_seed = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_hash;
    logic              out_is_seed;

    int checks = 0;
    int errors = 0;

    reverse_hash_peeler dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_hash(in_hash), .in_chars(in_chars), .in_len(in_len), .in_seed(in_seed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hash(out_hash), .out_is_seed(out_is_seed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fwd_step(input logic [31:0] h, input logic [6:0] c);
        logic [31:0] m;
        m = h * 32'd33;
        return m ^ {25'b0, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one job from a negedge with the block idle; returns at a negedge after
    // the output handshake. Latency = edges after accept until out_valid seen.
    task automatic run_job(input logic [31:0] h, input logic [CW-1:0] ch,
                           input logic [LEN_W-1:0] len, input logic [31:0] seed,
                           output logic [31:0] r_hash, output logic r_seed,
                           output int lat);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_hash = h; in_chars = ch; in_len = len; in_seed = seed; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r_hash = out_hash;
        r_seed = out_is_seed;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r_hash, h, seed, exp_h, held_h;
        logic        r_seed, held_s;
        logic [CW-1:0] ch;
        logic [6:0]  s [8];
        logic [31:0] st [9];
        int lat, k;

        // Reset state
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_hash", out_hash, 32'd0);
        check("reset_out_is_seed", 32'(out_is_seed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single char
        ch = '0; ch[6:0] = 7'h01;
        run_job(32'h0, ch, 4'd1, 32'h0, r_hash, r_seed, lat);
        $display("job single_char hash=%h is_seed=%0d lat=%0d", r_hash, r_seed, lat);
        check("t1_hash", r_hash, 32'h3E0F83E1);
        check("t1_is_seed", 32'(r_seed), 32'd0);
        check("t1_latency", lat, 32'd1);

        // Two chars, full inversion
        ch = '0; ch[6:0] = 7'h61; ch[13:7] = 7'h62;
        run_job(32'h00596E26, ch, 4'd2, 32'h1505, r_hash, r_seed, lat);
        $display("job two_chars hash=%h is_seed=%0d lat=%0d", r_hash, r_seed, lat);
        check("t2_hash", r_hash, 32'h00001505);
        check("t2_is_seed", 32'(r_seed), 32'd1);
        check("t2_latency", lat, 32'd2);

        // len=0 passthrough
        run_job(32'hDEADBEEF, '0, 4'd0, 32'hDEADBEEF, r_hash, r_seed, lat);
        $display("job len0 hash=%h is_seed=%0d lat=%0d", r_hash, r_seed, lat);
        check("t3_hash", r_hash, 32'hDEADBEEF);
        check("t3_is_seed", 32'(r_seed), 32'd1);
        check("t3_latency", lat, 32'd0);

        // len above MAX_CHARS clamps to MAX_CHARS
        seed = 32'h1234_5678; h = seed; ch = '0;
        for (int j = 0; j < 8; j++) begin
            s[j] = 7'($urandom); ch[j*7 +: 7] = s[j]; h = fwd_step(h, s[j]);
        end
        run_job(h, ch, 4'd15, seed, r_hash, r_seed, lat);
        $display("job len_clamp hash=%h is_seed=%0d lat=%0d", r_hash, r_seed, lat);
        check("clamp_hash", r_hash, seed);
        check("clamp_latency", lat, 32'd8);

        // Round trip, 1000 full strings
        for (int n = 0; n < 1000; n++) begin
            seed = $urandom; st[0] = seed; ch = '0;
            for (int j = 0; j < 8; j++) begin
                s[j] = 7'($urandom); ch[j*7 +: 7] = s[j];
                st[j+1] = fwd_step(st[j], s[j]);
            end
            run_job(st[8], ch, 4'd8, seed, r_hash, r_seed, lat);
            if (n < 3) $display("job round_trip %0d hash=%h is_seed=%0d", n, r_hash, r_seed);
            check("rt_hash", r_hash, seed);
            check("rt_is_seed", 32'(r_seed), 32'd1);
            check("rt_latency", lat, 32'd8);
        end

        // Partial peels: last k chars off the full hash give forward state after 8-k
        for (int n = 0; n < 200; n++) begin
            seed = $urandom; st[0] = seed;
            for (int j = 0; j < 8; j++) begin
                s[j] = 7'($urandom); st[j+1] = fwd_step(st[j], s[j]);
            end
            k = $urandom_range(0, 8);
            ch = '0;
            for (int j = 0; j < k; j++) ch[j*7 +: 7] = s[8-k+j];
            exp_h = st[8-k];
            run_job(st[8], ch, LEN_W'(k), seed, r_hash, r_seed, lat);
            if (n < 3) $display("job partial k=%0d hash=%h exp=%h", k, r_hash, exp_h);
            check("partial_hash", r_hash, exp_h);
            check("partial_is_seed", 32'(r_seed), 32'(exp_h == seed));
            check("partial_latency", lat, k);
        end

        // Backpressure with in_valid held high
        seed = 32'hCAFE0001; h = seed; ch = '0;
        for (int j = 0; j < 3; j++) begin
            s[j] = 7'($urandom); ch[j*7 +: 7] = s[j]; h = fwd_step(h, s[j]);
        end
        in_hash = h; in_chars = ch; in_len = 4'd3; in_seed = seed; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("bp_latency", lat, 32'd3);
        held_h = out_hash; held_s = out_is_seed;
        check("bp_hash", held_h, seed);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hash_stable", out_hash, held_h);
            check("bp_seed_stable", 32'(out_is_seed), 32'(held_s));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        $display("job backpressure hash=%h in_ready=%0d out_valid=%0d", held_h, in_ready, out_valid);
        check("bp_post_out_valid", 32'(out_valid), 32'd0);
        check("bp_post_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        check("bp_no_second_accept", 32'(in_ready), 32'd1);

        // Async reset mid-PEEL
        seed = $urandom; h = seed; ch = '0;
        for (int j = 0; j < 8; j++) begin
            s[j] = 7'($urandom); ch[j*7 +: 7] = s[j]; h = fwd_step(h, s[j]);
        end
        in_hash = h; in_chars = ch; in_len = 4'd8; in_seed = seed; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("job async_reset in_ready=%0d out_valid=%0d", in_ready, out_valid);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_hash", out_hash, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(h, ch, 4'd8, seed, r_hash, r_seed, lat);
        $display("job after_reset hash=%h is_seed=%0d lat=%0d", r_hash, r_seed, lat);
        check("rst_rerun_hash", r_hash, seed);
        check("rst_rerun_is_seed", 32'(r_seed), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
